cache_debug_sequencer: RTL

Hardware sequencer that drives the Data and Inst cache debug ports (A2/WD2/WE2/RD2) of RV32ICore in place of a simulation bench. It loads both caches from a word stream, pulses core reset, lets the core run for a fixed cycle budget, then dumps cache contents to an output stream. It sits between a host link (UART/JTAG bridge) and the core's debug ports on the Nexys4 top level.

---
 rtl/cache_debug_sequencer.sv | 257 +++++++++++++++++++++++++
 1 files changed

// File: rtl/cache_debug_sequencer.sv
`default_nettype none
// ============================================================================
// cache_debug_sequencer
//   Loads the Data/Inst caches through their debug ports, holds the core in
//   reset, runs it for a fixed cycle budget, then streams cache contents out.
//   Optional feature macro: DUMP_INST_EN (dump the Inst cache after the Data
//   cache).
//   Revision: 1.0
// ============================================================================
module cache_debug_sequencer #(
   parameter int WORDS      = 4096,
   parameter int RUN_CYCLES = 200000,
   parameter int RST_CYCLES = 5
) (
   input  logic        CPU_CLK,
   input  logic        CPU_RST_N,
   input  logic        start,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
   input  logic        in_last,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic        out_last,
   output logic [31:0] dcache_a2,
   output logic [31:0] dcache_wd2,
   output logic [3:0]  dcache_we2,
   input  logic [31:0] dcache_rd2,
   output logic [31:0] icache_a2,
   output logic [31:0] icache_wd2,
   output logic [3:0]  icache_we2,
   input  logic [31:0] icache_rd2,
   output logic        cpu_rst,
   output logic        busy,
   output logic        done
);

`ifdef DUMP_INST_EN
   localparam logic DUMP_INST = 1'b1;
`else
   localparam logic DUMP_INST = 1'b0;
`endif

   localparam int CW    = $clog2(WORDS) + 1;
   localparam int RCMAX = (RUN_CYCLES > RST_CYCLES) ? RUN_CYCLES : RST_CYCLES;
   localparam int RCW   = $clog2(RCMAX) + 1;

   typedef enum logic [3:0] {
      S_IDLE      = 4'd0,
      S_LOAD_D    = 4'd1,
      S_LOAD_I    = 4'd2,
      S_RUN_RST   = 4'd3,
      S_RUN       = 4'd4,
      S_DUMP_ADDR = 4'd5,
      S_DUMP_WAIT = 4'd6,
      S_DUMP_OUT  = 4'd7,
      S_DONE      = 4'd8
   } state_t;

   state_t           state_q;
   logic [CW-1:0]    cnt_q;
   logic [CW-1:0]    cnt_d;
   logic [31:0]      addr_q;
   logic [31:0]      addr_d;
   logic [RCW-1:0]   run_cnt_q;
   logic [RCW-1:0]   run_cnt_d;
   logic             inst_q;
   logic             in_ready_q;
   logic             out_valid_q;
   logic [31:0]      out_data_q;
   logic             out_last_q;
   logic [31:0]      dcache_a2_q;
   logic [31:0]      dcache_wd2_q;
   logic [3:0]       dcache_we2_q;
   logic [31:0]      icache_a2_q;
   logic [31:0]      icache_wd2_q;
   logic [3:0]       icache_we2_q;
   logic             cpu_rst_q;
   logic             busy_q;
   logic             done_q;
   logic [1:0]       rst_sync_q;
   logic             rst_n;
   logic             load_end;
   logic             dump_end;
   logic             last_phase;

   // Reset asserts asynchronously but releases in step with CPU_CLK.
   always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
      if (!CPU_RST_N) rst_sync_q <= 2'b00;
      else            rst_sync_q <= {rst_sync_q[0], 1'b1};
   end
   assign rst_n = rst_sync_q[1];

   assign cnt_d      = cnt_q + 1'b1;
   assign addr_d     = addr_q + 32'd4;
   assign run_cnt_d  = run_cnt_q + 1'b1;
   assign load_end   = in_last | (cnt_d == CW'(WORDS));
   assign dump_end   = (cnt_d == CW'(WORDS));
   assign last_phase = (inst_q == DUMP_INST);

   always_ff @(posedge CPU_CLK or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         addr_q       <= '0;
         run_cnt_q    <= '0;
         inst_q       <= 1'b0;
         in_ready_q   <= 1'b0;
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         out_last_q   <= 1'b0;
         dcache_a2_q  <= '0;
         dcache_wd2_q <= '0;
         dcache_we2_q <= '0;
         icache_a2_q  <= '0;
         icache_wd2_q <= '0;
         icache_we2_q <= '0;
         cpu_rst_q    <= 1'b1;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         // Byte enables are single-cycle pulses tied to an accepted word.
         dcache_we2_q <= '0;
         icache_we2_q <= '0;
         case (state_q)
            S_IDLE, S_DONE: begin
               if (state_q == S_DONE) begin
                  dcache_a2_q <= '0;
                  icache_a2_q <= '0;
               end
               if (start) begin
                  state_q    <= S_LOAD_D;
                  cnt_q      <= '0;
                  addr_q     <= '0;
                  inst_q     <= 1'b0;
                  in_ready_q <= 1'b1;
                  out_last_q <= 1'b0;
                  busy_q     <= 1'b1;
                  done_q     <= 1'b0;
               end
            end
            S_LOAD_D: begin
               if (in_valid) begin
                  dcache_a2_q  <= addr_q;
                  dcache_wd2_q <= in_data;
                  dcache_we2_q <= 4'b1111;
                  if (load_end) begin
                     state_q <= S_LOAD_I;
                     cnt_q   <= '0;
                     addr_q  <= '0;
                  end else begin
                     cnt_q   <= cnt_d;
                     addr_q  <= addr_d;
                  end
               end
            end
            S_LOAD_I: begin
               if (in_valid) begin
                  icache_a2_q  <= addr_q;
                  icache_wd2_q <= in_data;
                  icache_we2_q <= 4'b1111;
                  if (load_end) begin
                     state_q    <= S_RUN_RST;
                     in_ready_q <= 1'b0;
                     run_cnt_q  <= '0;
                     cnt_q      <= '0;
                     addr_q     <= '0;
                  end else begin
                     cnt_q      <= cnt_d;
                     addr_q     <= addr_d;
                  end
               end
            end
            S_RUN_RST: begin
               // The final load write has been presented; park both ports.
               dcache_a2_q  <= '0;
               dcache_wd2_q <= '0;
               icache_a2_q  <= '0;
               icache_wd2_q <= '0;
               if (run_cnt_q == RCW'(RST_CYCLES - 1)) begin
                  state_q   <= S_RUN;
                  run_cnt_q <= '0;
                  cpu_rst_q <= 1'b0;
               end else begin
                  run_cnt_q <= run_cnt_d;
               end
            end
            S_RUN: begin
               if (run_cnt_q == RCW'(RUN_CYCLES - 1)) begin
                  state_q     <= S_DUMP_ADDR;
                  run_cnt_q   <= '0;
                  cpu_rst_q   <= 1'b1;
                  cnt_q       <= '0;
                  addr_q      <= '0;
                  inst_q      <= 1'b0;
                  dcache_a2_q <= '0;
               end else begin
                  run_cnt_q <= run_cnt_d;
               end
            end
            S_DUMP_ADDR: begin
               state_q <= S_DUMP_WAIT;
            end
            S_DUMP_WAIT: begin
               state_q     <= S_DUMP_OUT;
               out_valid_q <= 1'b1;
               out_data_q  <= inst_q ? icache_rd2 : dcache_rd2;
               out_last_q  <= last_phase && (cnt_q == CW'(WORDS - 1));
            end
            S_DUMP_OUT: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  out_last_q  <= 1'b0;
                  if (dump_end && last_phase) begin
                     state_q <= S_DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end else if (dump_end) begin
                     state_q     <= S_DUMP_ADDR;
                     inst_q      <= 1'b1;
                     cnt_q       <= '0;
                     addr_q      <= '0;
                     dcache_a2_q <= '0;
                     icache_a2_q <= '0;
                  end else begin
                     state_q <= S_DUMP_ADDR;
                     cnt_q   <= cnt_d;
                     addr_q  <= addr_d;
                     if (inst_q) icache_a2_q <= addr_d;
                     else        dcache_a2_q <= addr_d;
                  end
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign in_ready   = in_ready_q;
   assign out_valid  = out_valid_q;
   assign out_data   = out_data_q;
   assign out_last   = out_last_q;
   assign dcache_a2  = dcache_a2_q;
   assign dcache_wd2 = dcache_wd2_q;
   assign dcache_we2 = dcache_we2_q;
   assign icache_a2  = icache_a2_q;
   assign icache_wd2 = icache_wd2_q;
   assign icache_we2 = icache_we2_q;
   assign cpu_rst    = cpu_rst_q;
   assign busy       = busy_q;
   assign done       = done_q;

endmodule
`default_nettype wire
